// File: rtl/key_int_conditioner.sv
// key_int_conditioner: pushbutton synchronizer/debouncer with edge pulses, sticky interrupts and stretched reset request.
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
module key_int_conditioner #(
    parameter int KEY_NUM           = 4,
    parameter int KEY_ACTIVE_LOW    = 1,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int CNT_WIDTH         = 20,
    parameter int RESET_KEY_IDX     = 0,
    parameter int RESET_HOLD_CYCLES = 16
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_PRESS_CYCLES = 100000000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_NUM-1:0] key_i,
    output logic [KEY_NUM-1:0] key_level_o,
    output logic [KEY_NUM-1:0] press_pulse_o,
    output logic [KEY_NUM-1:0] release_pulse_o,
    output logic [KEY_NUM-1:0] int_o,
    input  logic [KEY_NUM-1:0] int_ack_i,
    output logic               reset_req_o,
    output logic [KEY_NUM-1:0] long_press_o
);
    localparam int HW = $clog2(RESET_HOLD_CYCLES) + 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;
    logic [KEY_NUM-1:0] sync1, sync2, accept, lvl_nxt;
    state_t state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic req_nxt, rk;

    // Pipeline runs in pressed = 1 from the first flop on
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= KEY_ACTIVE_LOW != 0 ? ~key_i : key_i;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_deb
        logic [CNT_WIDTH-1:0] cnt;
        assign accept[k] = sync2[k] != key_level_o[k] && cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
        always_ff @(posedge clk) begin
            if (reset || sync2[k] == key_level_o[k] || accept[k]) cnt <= '0;
            else cnt <= cnt + 1'b1;
        end
    end

    assign lvl_nxt = (key_level_o & ~accept) | (sync2 & accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_level_o     <= '0;
            press_pulse_o   <= '0;
            release_pulse_o <= '0;
            int_o           <= '0;
        end else begin
            key_level_o     <= lvl_nxt;
            press_pulse_o   <= accept & sync2;
            release_pulse_o <= accept & ~sync2;
            int_o           <= (int_o & ~int_ack_i) | press_pulse_o;
        end
    end

    assign rk = key_level_o[RESET_KEY_IDX];

    // Stretch counter is reloaded every ACTIVE cycle so HOLD always starts full
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            reset_req_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            reset_req_o <= req_nxt;
            hold_cnt    <= state == ACTIVE ? HW'(RESET_HOLD_CYCLES - 1) :
                           (state == HOLD && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
        end
    end

    always_comb begin
        state_nxt = state == IDLE   ? (rk ? ACTIVE : IDLE) :
                    state == ACTIVE ? (rk ? ACTIVE : HOLD) :
                    rk ? ACTIVE : (hold_cnt == '0 ? IDLE : HOLD);
    end

    always_comb begin
        req_nxt = state_nxt != IDLE;
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_PRESS_CYCLES) + 1;
    for (genvar k = 0; k < KEY_NUM; k++) begin : g_long
        logic [LW-1:0] held;
        logic sat, long_q;
        assign sat = held == LW'(LONG_PRESS_CYCLES - 1);
        assign long_press_o[k] = long_q;
        always_ff @(posedge clk) begin
            if (reset || !lvl_nxt[k]) begin
                held   <= '0;
                long_q <= 1'b0;
            end else begin
                held   <= key_level_o[k] && !sat ? held + 1'b1 : held;
                long_q <= sat;
            end
        end
    end
`else
    assign long_press_o = '0;
`endif
endmodule

// File: tb/tb_key_int_conditioner.sv
// tb_key_int_conditioner: vector table with scoreboard queue plus hand-written debounce, ack-race, reset-stretch and long-press sequences.
module tb_key_int_conditioner;
    localparam int RH = 16;
`ifdef KEY_LONG_PRESS_EN
    localparam logic LP = 1'b1;
`else
    localparam logic LP = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] key_i = 4'hF, int_ack_i = 4'h0;
    logic [3:0] key_level_o, press_pulse_o, release_pulse_o, int_o, long_press_o;
    logic reset_req_o;

    key_int_conditioner #(
        .KEY_NUM(4), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3),
        .RESET_KEY_IDX(0), .RESET_HOLD_CYCLES(RH)
`ifdef KEY_LONG_PRESS_EN
        , .LONG_PRESS_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .reset(reset), .key_i(key_i), .key_level_o(key_level_o),
        .press_pulse_o(press_pulse_o), .release_pulse_o(release_pulse_o),
        .int_o(int_o), .int_ack_i(int_ack_i), .reset_req_o(reset_req_o),
        .long_press_o(long_press_o)
    );

    typedef struct {
        logic [3:0] key, ack;
        int         cyc;
        logic [3:0] lvl, intr;
        logic       rreq;
    } vec_t;
    typedef struct {
        logic [3:0] lvl, intr;
        logic       rreq;
    } exp_t;

    vec_t tv[10];
    exp_t exp_q[$];
    exp_t e;
    int n_chk = 0, n_pass = 0, both_cnt = 0, gap = 0;
    int press_cnt[4] = '{default: 0};
    int rel_cnt[4] = '{default: 0};
    logic [3:0] long_seen = 4'h0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((press_pulse_o & release_pulse_o) != 4'h0) both_cnt++;
        for (int k = 0; k < 4; k++) begin
            press_cnt[k] += int'(press_pulse_o[k]);
            rel_cnt[k] += int'(release_pulse_o[k]);
        end
        long_seen |= long_press_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{4'b0111, 4'b0000, 7, 4'b1000, 4'b1000, 1'b0};
        tv[1] = '{4'b0111, 4'b1000, 1, 4'b1000, 4'b0000, 1'b0};
        tv[2] = '{4'b0011, 4'b0000, 7, 4'b1100, 4'b0100, 1'b0};
        tv[3] = '{4'b1111, 4'b0000, 7, 4'b0000, 4'b0100, 1'b0};
        tv[4] = '{4'b1111, 4'b0100, 1, 4'b0000, 4'b0000, 1'b0};
        tv[5] = '{4'b1010, 4'b0000, 7, 4'b0101, 4'b0101, 1'b1};
        tv[6] = '{4'b1111, 4'b0000, 2, 4'b0101, 4'b0101, 1'b1};
        tv[7] = '{4'b1010, 4'b0000, 7, 4'b0101, 4'b0101, 1'b1};
        tv[8] = '{4'b1111, 4'b0101, 7, 4'b0000, 4'b0000, 1'b1};
        tv[9] = '{4'b1111, 4'b0000, 20, 4'b0000, 4'b0000, 1'b0};

        step(3);
        chk("rst_level", key_level_o, 0);
        chk("rst_pulses", {press_pulse_o, release_pulse_o}, 0);
        chk("rst_int", int_o, 0);
        chk("rst_req", reset_req_o, 0);
        chk("rst_long", long_press_o, 0);
        reset = 1'b0;
        step(2);

        // clean press of key 1
        key_i = 4'b1101;
        step(5);
        chk("press_early_level", key_level_o[1], 0);
        step(1);
        chk("press_level", key_level_o[1], 1);
        chk("press_pulse", press_pulse_o[1], 1);
        chk("press_int_lag", int_o[1], 0);
        step(1);
        chk("press_pulse_end", press_pulse_o[1], 0);
        chk("press_int", int_o[1], 1);

        // release, then re-press with ack racing the new pulse
        key_i = 4'hF;
        step(6);
        chk("rel_pulse", release_pulse_o[1], 1);
        chk("rel_level", key_level_o[1], 0);
        key_i = 4'b1101;
        step(6);
        chk("race_pulse", press_pulse_o[1], 1);
        int_ack_i = 4'b0010;
        step(1);
        chk("race_set_wins", int_o[1], 1);
        step(1);
        chk("ack_clears", int_o[1], 0);
        int_ack_i = 4'h0;
        key_i = 4'hF;
        step(8);

        // bouncing key 2
        for (int i = 0; i < 5; i++) begin
            key_i = 4'b1011;
            step(2);
            key_i = 4'hF;
            step(2);
        end
        chk("bounce_no_pulse", press_cnt[2], 0);
        chk("bounce_level", key_level_o[2], 0);
        key_i = 4'b1011;
        step(5);
        chk("settle_early", key_level_o[2], 0);
        step(1);
        chk("settle_pulse", press_pulse_o[2], 1);
        step(5);
        chk("settle_once", press_cnt[2], 1);
        key_i = 4'hF;
        step(8);
        int_ack_i = 4'hF;
        step(1);
        int_ack_i = 4'h0;

        // reset key: press 30 cycles, release, stretch
        key_i = 4'b1110;
        step(6);
        chk("rk_level", key_level_o[0], 1);
        chk("rk_req_lag", reset_req_o, 0);
        step(1);
        chk("rk_req_on", reset_req_o, 1);
        gap = 0;
        for (int i = 0; i < 23; i++) begin
            step(1);
            if (!reset_req_o) gap++;
        end
        key_i = 4'hF;
        for (int i = 0; i < 22; i++) begin
            step(1);
            if (!reset_req_o) gap++;
        end
        chk("rk_req_held", gap, 0);
        chk("rk_rel_pulses", rel_cnt[0], 1);
        step(1);
        chk("rk_req_off", reset_req_o, 0);

        // re-press during HOLD keeps the request up
        key_i = 4'b1110;
        step(8);
        key_i = 4'hF;
        step(6);
        chk("rk2_rel_pulse", release_pulse_o[0], 1);
        key_i = 4'b1110;
        gap = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (!reset_req_o) gap++;
        end
        chk("rk2_no_gap", gap, 0);
        key_i = 4'hF;
        step(30);
        chk("rk2_req_off", reset_req_o, 0);
        int_ack_i = 4'hF;
        step(1);
        int_ack_i = 4'h0;
        step(1);

        for (int i = 0; i < 10; i++) begin
            key_i = tv[i].key;
            int_ack_i = tv[i].ack;
            exp_q.push_back('{tv[i].lvl, tv[i].intr, tv[i].rreq});
            step(tv[i].cyc);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_level", i), key_level_o, e.lvl);
            chk($sformatf("vec%0d_int", i), int_o, e.intr);
            chk($sformatf("vec%0d_req", i), reset_req_o, e.rreq);
        end
        int_ack_i = 4'h0;

        // long press on key 3
        long_seen = 4'h0;
        key_i = 4'b0111;
        step(6);
        chk("lp_level", key_level_o[3], 1);
        step(7);
        chk("lp_early", long_press_o[3], 0);
        step(1);
        chk("lp_on", long_press_o[3], LP);
        key_i = 4'hF;
        step(5);
        chk("lp_hold", long_press_o[3], LP);
        step(1);
        chk("lp_off", long_press_o[3], 0);
        chk("lp_level_off", key_level_o[3], 0);
        step(2);
        chk("lp_seen", long_seen, {LP, 3'b000});
        chk("pulse_excl", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/key_int_conditioner.md
Name: key_int_conditioner

Overview:
- Input-side counterpart to the MPSoC GPIO output path: conditions raw active-low board pushbuttons into clean interrupt requests and a reset request for the aeMB MPSoC.
- Per key: 2-flop synchronizer, counter-based debouncer, press/release edge pulses, sticky interrupt pending bit with per-bit acknowledge.
- One key is designated as reset key; its debounced press produces a stretched reset request.
- Instantiated at board top between KEY[] and the MPSoC ext_int_i / reset inputs.

Parameters:
- KEY_NUM, 4, number of keys handled.
- KEY_ACTIVE_LOW, 1, 1: pressed = key_i bit low; 0: pressed = high.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); minimum 2.
- CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- RESET_KEY_IDX, 0, index of the key driving reset_req_o.
- RESET_HOLD_CYCLES, 16, cycles reset_req_o stays high after the reset key's debounced release; minimum 1.

Ports:
- clk, input, 1, single system clock.
- reset, input, 1, synchronous, active-high reset.
- key_i, input, KEY_NUM, raw asynchronous pushbutton pins.
- key_level_o, output, KEY_NUM, debounced level, 1 = pressed.
- press_pulse_o, output, KEY_NUM, one-cycle pulse on accepted press.
- release_pulse_o, output, KEY_NUM, one-cycle pulse on accepted release.
- int_o, output, KEY_NUM, sticky pending interrupt per key, to ext_int_i.
- int_ack_i, input, KEY_NUM, per-bit clear of int_o.
- reset_req_o, output, 1, stretched reset request from key RESET_KEY_IDX.
- long_press_o, output, KEY_NUM, long-press flag (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state changes only on the rising clk edge.
- Reset values:
  - Synchronizer flops: unpressed level.
  - Debounce counters: 0.
  - key_level_o, press_pulse_o, release_pulse_o, int_o, long_press_o: all 0.
  - reset_req_o: 0; stretch counter: 0.
  - Reset mid-debounce discards partial counts.
- Polarity: raw input is inverted when KEY_ACTIVE_LOW=1 before the synchronizer, so the pipeline works in pressed = 1.
- Synchronizer: two flops per key. No logic except polarity inversion before the first flop.
- Debouncer, per key:
  - If sync2 == key_level_o: counter cleared to 0.
  - Else: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 with sync2 still != level: key_level_o takes sync2 and counter clears.
  - Any glitch back to the current level before that point clears the counter; no partial credit.
- Latency: a clean input change sampled at edge N appears on key_level_o after edge N+1+DEBOUNCE_CYCLES.
- Edge pulses: registered. press_pulse_o is high exactly in the first cycle key_level_o reads 1; release_pulse_o likewise for 0. Never both high for the same key.
- Interrupt pending, per bit:
  - Set by press_pulse_o; cleared by int_ack_i.
  - Simultaneous set and ack: set wins, bit stays 1.
  - Ack on an already-clear bit: no effect.
  - Release does not set int_o.
- Reset-request states:
  - IDLE: reset_req_o=0. Go to ACTIVE when key_level_o[RESET_KEY_IDX]=1.
  - ACTIVE: reset_req_o=1. Go to HOLD on release, loading stretch counter with RESET_HOLD_CYCLES-1.
  - HOLD: reset_req_o=1, counter decrements. Re-press returns to ACTIVE. Counter==0 goes to IDLE; reset_req_o drops in the following cycle.
  - reset_req_o is registered.
  - reset_req_o must not drive this block's own reset input; the board top ORs it only into the MPSoC reset.
- The reset key also generates press/release pulses and int_o like any other key.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - Adds parameter LONG_PRESS_CYCLES (default 100000000) and a per-key hold counter.
  - The hold counter runs while key_level_o=1 and saturates.
  - long_press_o asserts when the count reaches LONG_PRESS_CYCLES-1 and stays high until the debounced release.
  - The hold counter clears on release or reset.
- Undefined: no hold counters are built and long_press_o is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset: assert reset 3 cycles with key_i=4'hF -> all outputs 0, key_level_o=0.
- Clean press (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1): drive key_i[1]=0 at edge 10 and hold -> key_level_o[1]=1 and press_pulse_o[1]=1 after edge 15; pulse low after edge 16; int_o[1]=1 after edge 16.
- Bounce: key_i[2] toggles 0/1 every 2 cycles for 20 cycles, then holds 0 -> no pulse during bouncing; press_pulse_o[2] exactly once, 5 edges after the final settle.
- Ack race: int_o[1]=1; assert int_ack_i[1] in the same cycle as a new press_pulse_o[1] -> int_o[1] remains 1; ack one cycle later -> int_o[1]=0.
- Reset key (RESET_HOLD_CYCLES=16): press key 0 for 30 cycles, then release -> reset_req_o high from debounced press through 16 cycles after release_pulse_o[0], then 0. Re-press during HOLD -> stays 1 with no gap.
- Long press (KEY_LONG_PRESS_EN defined, LONG_PRESS_CYCLES=8): hold key 3 -> long_press_o[3]=1 eight cycles after key_level_o[3] rises; drops with debounced release. Rerun without the macro -> long_press_o stays 0.
